// File: rtl/systolic_feeder_if.sv
// Load handshake and skewed array-edge streams of the systolic feeder.
interface systolic_feeder_if #(
  parameter int DATA_SIZE = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*DATA_SIZE-1:0] in_a;
  logic [4*DATA_SIZE-1:0] in_b;
  logic [DATA_SIZE-1:0]   a1, a2, a3, a4;
  logic [DATA_SIZE-1:0]   b1, b2, b3, b4;
  logic                   busy;
  logic                   done;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, a1, a2, a3, a4, b1, b2, b3, b4, busy, done
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, a1, a2, a3, a4, b1, b2, b3, b4, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers four A-column/B-row beats and streams them diagonally skewed into a 4x4 systolic array.
// Optional macro FEEDER_DBLBUF_EN adds a shadow operand bank so the next job loads while one feeds.
module systolic_feeder #(
  parameter int DATA_SIZE    = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  systolic_feeder_if.slave  bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_FEED, ST_DRAIN, ST_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_k, w_k_nxt;
  logic [2:0]           r_t, w_t_nxt;
  logic [DW-1:0]        r_drain, w_drain_nxt;
  logic                 r_in_ready, w_ready_nxt;
  logic                 w_accept;
  logic                 w_wr_en;
  logic [1:0]           w_wr_k;
  logic [DATA_SIZE-1:0] r_a [4];
  logic [DATA_SIZE-1:0] r_b [4];
  logic [DATA_SIZE-1:0] w_a_nxt [4];
  logic [DATA_SIZE-1:0] w_b_nxt [4];
  logic [DATA_SIZE-1:0] w_rd_a [4][4];
  logic [DATA_SIZE-1:0] w_rd_b [4][4];

`ifdef FEEDER_DBLBUF_EN
  logic [DATA_SIZE-1:0] r_bank_a [2][4][4];
  logic [DATA_SIZE-1:0] r_bank_b [2][4][4];
  logic                 r_sel, w_sel_nxt, w_wr_bank;
  logic [2:0]           r_sh_cnt, w_sh_nxt;
`else
  logic [DATA_SIZE-1:0] r_bank_a [4][4];
  logic [DATA_SIZE-1:0] r_bank_b [4][4];
`endif

  assign w_accept = bus.in_valid & r_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_t_nxt     = r_t;
    w_drain_nxt = r_drain;
    w_wr_en     = 1'b0;
    w_wr_k      = r_k;
`ifdef FEEDER_DBLBUF_EN
    w_sel_nxt   = r_sel;
    w_sh_nxt    = r_sh_cnt;
    w_wr_bank   = r_sel;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_wr_en     = 1'b1;
          w_wr_k      = 2'd0;
          w_k_nxt     = 2'd1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          w_wr_k  = r_k;
          w_k_nxt = r_k + 2'd1;
          if (r_k == 2'd3) begin
            w_state_nxt = ST_FEED;
            w_t_nxt     = '0;
          end
        end
      end
      ST_FEED: begin
        if (r_t == 3'd6) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_t_nxt = r_t + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (r_drain == DW'(DRAIN_CYCLES - 1)) w_state_nxt = ST_DONE;
        else                                  w_drain_nxt = r_drain + DW'(1);
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_t_nxt     = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

`ifdef FEEDER_DBLBUF_EN
    if ((r_state inside {ST_FEED, ST_DRAIN, ST_DONE}) && w_accept) begin
      w_wr_en   = 1'b1;
      w_wr_bank = ~r_sel;
      w_wr_k    = r_sh_cnt[1:0];
      w_sh_nxt  = r_sh_cnt + 3'd1;
    end
    // Leaving DONE, the shadow bank becomes active: full -> feed at once, partial -> keep loading.
    if (r_state == ST_DONE) begin
      if (w_sh_nxt == 3'd4) begin
        w_state_nxt = ST_FEED;
        w_t_nxt     = '0;
        w_k_nxt     = '0;
        w_sel_nxt   = ~r_sel;
        w_sh_nxt    = '0;
      end else if (w_sh_nxt != 3'd0) begin
        w_state_nxt = ST_LOAD;
        w_k_nxt     = w_sh_nxt[1:0];
        w_sel_nxt   = ~r_sel;
        w_sh_nxt    = '0;
      end
    end
    w_ready_nxt = (w_sh_nxt != 3'd4);
`else
    w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
`endif
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
`ifdef FEEDER_DBLBUF_EN
        w_rd_a[i][k] = r_bank_a[w_sel_nxt][i][k];
        w_rd_b[i][k] = r_bank_b[w_sel_nxt][i][k];
`else
        w_rd_a[i][k] = r_bank_a[i][k];
        w_rd_b[i][k] = r_bank_b[i][k];
`endif
      end
    end
  end

  // Lane i carries element k exactly when the upcoming feed step equals i+k.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_a_nxt[i] = '0;
      w_b_nxt[i] = '0;
    end
    if (w_state_nxt == ST_FEED) begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (w_t_nxt == 3'(i + k)) begin
            w_a_nxt[i] = w_rd_a[i][k];
            w_b_nxt[i] = w_rd_b[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_t        <= '0;
      r_drain    <= '0;
      r_in_ready <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
`ifdef FEEDER_DBLBUF_EN
      r_sel    <= 1'b0;
      r_sh_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_t        <= w_t_nxt;
      r_drain    <= w_drain_nxt;
      r_in_ready <= w_ready_nxt;
      for (int unsigned i = 0; i < 4; i++) begin
        r_a[i] <= w_a_nxt[i];
        r_b[i] <= w_b_nxt[i];
      end
`ifdef FEEDER_DBLBUF_EN
      r_sel    <= w_sel_nxt;
      r_sh_cnt <= w_sh_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
`ifdef FEEDER_DBLBUF_EN
        r_bank_a[w_wr_bank][i][w_wr_k] <= bus.in_a[i*DATA_SIZE +: DATA_SIZE];
        r_bank_b[w_wr_bank][w_wr_k][i] <= bus.in_b[i*DATA_SIZE +: DATA_SIZE];
`else
        r_bank_a[i][w_wr_k] <= bus.in_a[i*DATA_SIZE +: DATA_SIZE];
        r_bank_b[w_wr_k][i] <= bus.in_b[i*DATA_SIZE +: DATA_SIZE];
`endif
      end
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.a1       = r_a[0];
  assign bus.a2       = r_a[1];
  assign bus.a3       = r_a[2];
  assign bus.a4       = r_a[3];
  assign bus.b1       = r_b[0];
  assign bus.b2       = r_b[1];
  assign bus.b3       = r_b[2];
  assign bus.b4       = r_b[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: cycle table for skew/timing, plus stall, array end-to-end and reset sequences.
module tb_systolic_feeder;
  localparam int DS = 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   n_chk = 0;
  int   n_fail = 0;

  systolic_feeder_if #(.DATA_SIZE(DS)) bus_if ();

  systolic_feeder #(.DATA_SIZE(DS), .DRAIN_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] w_a, w_b;
  assign w_a = {bus_if.a4, bus_if.a3, bus_if.a2, bus_if.a1};
  assign w_b = {bus_if.b4, bus_if.b3, bus_if.b2, bus_if.b1};

  // Reference 4x4 output-stationary array: a flows right, b flows down, c accumulates.
  logic [DS-1:0] la [4];
  logic [DS-1:0] lb [4];
  logic [DS-1:0] pa [4][4];
  logic [DS-1:0] pb [4][4];
  logic [31:0]   c  [4][4];

  always_comb begin
    la[0] = bus_if.a1; la[1] = bus_if.a2; la[2] = bus_if.a3; la[3] = bus_if.a4;
    lb[0] = bus_if.b1; lb[1] = bus_if.b2; lb[2] = bus_if.b3; lb[3] = bus_if.b4;
  end

  function automatic logic [DS-1:0] fa(input int i, input int j);
    if (j == 0) return la[i];
    return pa[i][j-1];
  endfunction

  function automatic logic [DS-1:0] fb(input int i, input int j);
    if (i == 0) return lb[j];
    return pb[i-1][j];
  endfunction

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        pa[i][j] = '0;
        pb[i][j] = '0;
        c[i][j]  = '0;
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        c[i][j]  <= clr ? 32'd0 : c[i][j] + 32'(fa(i, j)) * 32'(fb(i, j));
        pa[i][j] <= fa(i, j);
        pb[i][j] <= fb(i, j);
      end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(posedge clk); #1;
      if (bus_if.done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic check_c(input string name);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_c%0d%0d", name, i, j), c[i][j], 32'(4*i + j + 1));
  endtask

  typedef struct {
    logic        v;
    logic [31:0] ia, ib, ea, eb;
    logic        bsy, dn, rdy;
  } vec_t;

  vec_t        tbl [16];
  logic        pat [7];
  logic [31:0] ida [4];
  logic [31:0] idb [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  beat;
    bit  seen;
    logic exp_rdy;

    // Skew job: A[i][k]=16i+k+1, B[k][j]=16k+j+0x81; {a4..a1},{b4..b1} per row.
    tbl[0]  = '{1'b1, 32'h31211101, 32'h84838281, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 32'h32221202, 32'h94939291, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'h33231303, 32'hA4A3A2A1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 32'h34241404, 32'hB4B3B2B1, 32'h00000001, 32'h00000081, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        32'h0,        32'h00001102, 32'h00008291, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,        32'h0,        32'h00211203, 32'h008392A1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,        32'h0,        32'h31221304, 32'h8493A2B1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,        32'h0,        32'h32231400, 32'h94A3B200, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        32'h0,        32'h33240000, 32'hA4B30000, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        32'h0,        32'h34000000, 32'hB4000000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};

    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    // Identity A, B entries 1..16 row-major.
    ida = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
    idb = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

    bus_if.in_valid = 1'b0;
    bus_if.in_a     = '0;
    bus_if.in_b     = '0;
    clr             = 1'b1;
    rst             = 1'b1;
    #1 rst = 1'b0;
    #11;
    chk("rst_a",     w_a, 32'h0);
    chk("rst_b",     w_b, 32'h0);
    chk("rst_busy",  32'(bus_if.busy), 32'd0);
    chk("rst_done",  32'(bus_if.done), 32'd0);
    chk("rst_ready", 32'(bus_if.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus_if.in_ready), 32'd1);
    chk("post_rst_busy",  32'(bus_if.busy), 32'd0);

    for (int r = 0; r < 16; r++) begin
      bus_if.in_valid = tbl[r].v;
      bus_if.in_a     = tbl[r].ia;
      bus_if.in_b     = tbl[r].ib;
      @(posedge clk); #1;
`ifdef FEEDER_DBLBUF_EN
      exp_rdy = 1'b1;
`else
      exp_rdy = tbl[r].rdy;
`endif
      chk($sformatf("row%0d_a", r),     w_a, tbl[r].ea);
      chk($sformatf("row%0d_b", r),     w_b, tbl[r].eb);
      chk($sformatf("row%0d_busy", r),  32'(bus_if.busy), 32'(tbl[r].bsy));
      chk($sformatf("row%0d_done", r),  32'(bus_if.done), 32'(tbl[r].dn));
      chk($sformatf("row%0d_ready", r), 32'(bus_if.in_ready), 32'(exp_rdy));
    end

    // Stalled load of the identity job; junk on idle cycles must not be stored.
    clr  = 1'b0;
    beat = 0;
    for (int s = 0; s < 7; s++) begin
      bus_if.in_valid = pat[s];
      bus_if.in_a     = pat[s] ? ida[beat] : 32'hDEADBEEF;
      bus_if.in_b     = pat[s] ? idb[beat] : 32'hDEADBEEF;
      @(posedge clk); #1;
      if (pat[s]) beat++;
      if (s < 6) begin
        chk($sformatf("stall%0d_a", s),    w_a, 32'h0);
        chk($sformatf("stall%0d_busy", s), 32'(bus_if.busy), 32'd1);
      end else begin
        chk("stall_feed_a", w_a, 32'h00000001);
        chk("stall_feed_b", w_b, 32'h00000001);
      end
    end

`ifdef FEEDER_DBLBUF_EN
    for (int k = 0; k < 4; k++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = tbl[k].ia;
      bus_if.in_b     = tbl[k].ib;
      chk($sformatf("shadow_ready%0d", k), 32'(bus_if.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    chk("shadow_full_ready", 32'(bus_if.in_ready), 32'd0);
    wait_done("e2e_done");
    check_c("e2e");
    @(posedge clk); #1;
    chk("swap_busy", 32'(bus_if.busy), 32'd1);
    chk("swap_a",    w_a, 32'h00000001);
    chk("swap_b",    w_b, 32'h00000081);
    wait_done("swap_done");
    @(posedge clk); #1;
`else
    for (int k = 0; k < 3; k++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = 32'h55555555;
      bus_if.in_b     = 32'hAAAAAAAA;
      chk($sformatf("feed_ready%0d", k), 32'(bus_if.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    wait_done("e2e_done");
    check_c("e2e");
    @(posedge clk); #1;
    chk("after_done_busy", 32'(bus_if.busy), 32'd0);
    chk("after_done_done", 32'(bus_if.done), 32'd0);
`endif

    // Asynchronous reset in the middle of FEED aborts the job.
    for (int k = 0; k < 4; k++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = tbl[k].ia;
      bus_if.in_b     = tbl[k].ib;
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_a", w_a, 32'h00001102);
    #2 rst = 1'b0;
    #1;
    chk("abort_a",     w_a, 32'h0);
    chk("abort_b",     w_b, 32'h0);
    chk("abort_busy",  32'(bus_if.busy), 32'd0);
    chk("abort_ready", 32'(bus_if.in_ready), 32'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rel_ready", 32'(bus_if.in_ready), 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus_if.done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_idle",    32'(bus_if.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter DATA_SIZE, default 8, SHALL set operand width in bits.
REQ-002 Parameter DRAIN_CYCLES, default 4, SHALL set idle cycles after feeding before done.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  SHALL qualify one load beat.
REQ-006 in_ready  output  1  SHALL indicate a beat is accepted when in_valid=1 on that edge.
REQ-007 in_a  input  4*DATA_SIZE  SHALL carry column k of A: lane i (bits i*DATA_SIZE +: DATA_SIZE) = A[i][k].
REQ-008 in_b  input  4*DATA_SIZE  SHALL carry row k of B: lane j = B[k][j].
REQ-009 a1..a4  output  DATA_SIZE each  SHALL be skewed A row streams into the array's left edge.
REQ-010 b1..b4  output  DATA_SIZE each  SHALL be skewed B column streams into the array's top edge.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 done  output  1  SHALL pulse high one cycle when the array's 16 results are final.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, FEED, DRAIN, DONE.
REQ-014 IDLE: in_ready=1; an accepted beat stores k=0, moves to LOAD.
REQ-015 LOAD: in_ready=1; beats stored at k=1,2,3 in acceptance order; the 4th beat (k=3) moves to FEED on that edge.
REQ-016 in_valid=0 in IDLE/LOAD SHALL hold state and beat counter unchanged (no timeout).
REQ-017 FEED SHALL last exactly 7 cycles, t=0..6; during cycle t, registered outputs SHALL be a(i+1)=A[i][t-i] and b(j+1)=B[t-j][j] when 0<=t-i<=3 (resp. t-j), else 0.
REQ-018 First FEED cycle SHALL be the cycle immediately after the edge accepting beat k=3 (no bubble).
REQ-019 DRAIN SHALL last DRAIN_CYCLES cycles with all a*/b* = 0; then DONE for one cycle (done=1), then IDLE.
REQ-020 Outside FEED, a1..a4 and b1..b4 SHALL be 0.
REQ-021 Data SHALL pass unmodified (no sign extension, no arithmetic); widths exactly DATA_SIZE.
REQ-022 Without FEEDER_DBLBUF_EN, in_ready SHALL be 0 in FEED, DRAIN, DONE; in_valid there is ignored.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, beat counter 0, feed counter 0, a*/b*=0, done=0, busy=0, in_ready=0 while asserted.
REQ-024 After rst deasserts, in_ready SHALL be 1 from the first clock edge onward (IDLE).
REQ-025 Reset mid-LOAD/FEED/DRAIN SHALL discard stored beats; no done pulse for the aborted job.

Configuration
REQ-026 Macro FEEDER_DBLBUF_EN SHALL, when defined, add a second 4-beat operand bank.
REQ-027 With it: in_ready=1 in FEED/DRAIN/DONE until the shadow bank holds 4 beats; beats fill the shadow bank in order.
REQ-028 With it: if the shadow bank is full when DONE is active, the next cycle SHALL be FEED t=0 from the shadow bank (banks swap), else IDLE; a partially filled shadow bank SHALL continue as LOAD (k preserved).
REQ-029 Without it: single bank, behaviour per REQ-022, no shadow storage synthesized.

Verification
REQ-030 Reset: rst=0 mid-FEED -> a*/b*=0, busy=0 immediately (async); after release, in_ready=1, no done.
REQ-031 Skew: load A[i][k]=16*i+k+1, B[k][j]=16*k+j+0x81 over 4 back-to-back beats -> cycle t=3: a1..a4=0x04,0x13,0x22,0x31; b1..b4=0xB1,0xA2,0x93,0x84; t=6: a4=0x34, b4=0xB4, others 0.
REQ-032 Stalls: in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats stored; FEED starts one cycle after 4th acceptance.
REQ-033 Timing: last beat at edge N -> FEED cycles N+1..N+7, DRAIN N+8..N+11, done=1 only at N+12, busy=0 at N+13.
REQ-034 End-to-end with systolic array: A=identity, B entries 1..16 -> array outputs c1..c16 = 1..16 at done.
REQ-035 FEEDER_DBLBUF_EN: second job's 4 beats during first FEED -> second FEED starts the cycle after done, no IDLE cycle; without macro in_ready=0 throughout first FEED.
